card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 111 +++++++++++
 tb/tb_card_dealer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Deals a hand of four cards from an upstream pseudo-random source.
// Out-of-range values are rejected, and a fallback value is forced so the draw never stalls.
module card_dealer #(
   parameter int MAX_VAL   = 13,
   parameter int REJ_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       deal,
   input  logic [3:0] rand_in,
   output logic       rand_en,
   output logic [3:0] card0,
   output logic [3:0] card1,
   output logic [3:0] card2,
   output logic [3:0] card3,
   output logic       valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [1:0]      slot_q;
   logic [3:0]      rej_q;
   logic [3:0][3:0] card_q;
   logic            valid_q;
   logic            busy_q;

   logic            cand_ok_d;
   logic [3:0]      rej_inc_d;
   logic            load_d;
   logic [3:0]      load_val_d;
   logic [3:0]      rej_d;

   // Candidate evaluation: a value is loaded when it is in range, or when the reject run hits its limit.
   always_comb begin
      cand_ok_d  = 1'b0;
      rej_inc_d  = 4'd0;
      load_d     = 1'b0;
      load_val_d = 4'd0;
      rej_d      = 4'd0;
      cand_ok_d  = (rand_in >= 4'd1) && (rand_in <= 4'(MAX_VAL));
      rej_inc_d  = rej_q + 4'd1;
      load_d     = cand_ok_d || (rej_inc_d == 4'(REJ_LIMIT));
      if (cand_ok_d) begin
         load_val_d = rand_in;
      end else begin
         load_val_d = {2'b00, slot_q} + 4'd1;
      end
      if (load_d) begin
         rej_d = 4'd0;
      end else begin
         rej_d = rej_inc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         slot_q  <= 2'd0;
         rej_q   <= 4'd0;
         card_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (deal) begin
                  state_q <= ST_DRAW;
                  slot_q  <= 2'd0;
                  rej_q   <= 4'd0;
                  card_q  <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_DRAW: begin
               // deal is deliberately ignored here; the draw in progress runs to completion.
               rej_q <= rej_d;
               if (load_d) begin
                  card_q[slot_q] <= load_val_d;
                  slot_q         <= slot_q + 2'd1;
                  if (slot_q == 2'd3) begin
                     state_q <= ST_DONE;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign card0   = card_q[0];
   assign card1   = card_q[1];
   assign card2   = card_q[2];
   assign card3   = card_q[3];
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign rand_en = busy_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed, self-checking bench for card_dealer: a table of draw sequences plus hand-written corner cases.
module tb_card_dealer;

   logic       clk = 1'b0;
   logic       rst, deal, deal9;
   logic [3:0] rand_in, rand9;
   logic       rand_en, valid, busy;
   logic [3:0] card0, card1, card2, card3;
   logic       rand_en9, valid9, busy9;
   logic [3:0] c90, c91, c92, c93;

   int pass_cnt  = 0;
   int total_cnt = 0;

   card_dealer dut (
      .clk(clk), .rst(rst), .deal(deal), .rand_in(rand_in), .rand_en(rand_en),
      .card0(card0), .card1(card1), .card2(card2), .card3(card3),
      .valid(valid), .busy(busy)
   );

   card_dealer #(.MAX_VAL(9), .REJ_LIMIT(8)) dut9 (
      .clk(clk), .rst(rst), .deal(deal9), .rand_in(rand9), .rand_en(rand_en9),
      .card0(c90), .card1(c91), .card2(c92), .card3(c93),
      .valid(valid9), .busy(busy9)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          n;
      logic [31:0] seq;    // first rand_in value in the top nibble
      logic [15:0] cards;  // {card0, card1, card2, card3}
   } vec_t;

   vec_t vecs[4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic logic [15:0] hand();
      return {card0, card1, card2, card3};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"basic_3_7_1_13",  4, 32'h371D_0000, 16'h371D};
      vecs[1] = '{"reject_0_14_15",  7, 32'h0E5F_29B0, 16'h529B};
      vecs[2] = '{"bounds_dups",     4, 32'h1DD1_0000, 16'h1DD1};
      vecs[3] = '{"rej_cnt_clears",  7, 32'h0060_6660, 16'h6666};

      rst = 1'b1; deal = 1'b0; deal9 = 1'b0; rand_in = 4'd0; rand9 = 4'd0;
      step();
      step();
      chk("reset_cards", {16'd0, hand()}, 32'd0);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_busy", {30'd0, busy, rand_en}, 32'd0);
      chk("reset_dut9", {13'd0, valid9, busy9, rand_en9, c90, c91, c92, c93}, 32'd0);

      // Deal on the very first edge with reset released.
      rst = 1'b0; deal = 1'b1;
      step();
      deal = 1'b0;
      chk("first_deal_busy", {30'd0, busy, rand_en}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         rand_in = 4'd2;
         step();
      end
      chk("first_deal_cards", {16'd0, hand()}, 32'h2222);
      chk("first_deal_valid", {31'd0, valid}, 32'd1);

      for (int v = 0; v < 4; v++) begin
         deal = 1'b1;
         step();
         deal = 1'b0;
         chk({vecs[v].name, "_start"}, {13'd0, busy, rand_en, valid, hand()}, 32'h6_0000);
         for (int i = 0; i < vecs[v].n; i++) begin
            rand_in = vecs[v].seq[31 - 4*i -: 4];
            if (i == vecs[v].n - 1) chk({vecs[v].name, "_not_early"}, {31'd0, valid}, 32'd0);
            step();
         end
         chk({vecs[v].name, "_cards"}, {16'd0, hand()}, {16'd0, vecs[v].cards});
         chk({vecs[v].name, "_done"}, {30'd0, valid, busy}, 32'd2);
         rand_in = 4'd5;
         step();
         step();
         chk({vecs[v].name, "_hold"}, {15'd0, valid, hand()}, {15'd0, 1'b1, vecs[v].cards});
      end

      // LFSR lock-up: rand_in stuck at 15 forces fallback values 1..4.
      deal = 1'b1;
      step();
      deal = 1'b0;
      rand_in = 4'hF;
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 7)  chk("lock_card0_pending", {28'd0, card0}, 32'd0);
         if (i == 8)  chk("lock_card0_forced", {28'd0, card0}, 32'd1);
         if (i == 31) chk("lock_not_early", {31'd0, valid}, 32'd0);
      end
      chk("lock_cards", {16'd0, hand()}, 32'h1234);
      chk("lock_done", {30'd0, valid, busy}, 32'd2);

      // Reset after two accepts.
      deal = 1'b1;
      step();
      deal = 1'b0;
      rand_in = 4'd4; step();
      rand_in = 4'd5; step();
      chk("mid_two_accepts", {16'd0, hand()}, 32'h4500);
      rst = 1'b1; rand_in = 4'd6;
      step();
      chk("mid_rst_state", {13'd0, valid, busy, rand_en, hand()}, 32'd0);
      rst = 1'b0; deal = 1'b1;
      step();
      deal = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_in = 4'(i + 9);
         step();
      end
      chk("after_rst_hand", {15'd0, valid, hand()}, 32'h1_9ABC);

      // deal held high through DRAW and into DONE.
      deal = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         rand_in = 4'(i + 1);
         step();
      end
      chk("held_first_hand", {14'd0, valid, busy, hand()}, 32'h2_1234);
      step();
      chk("held_redeal", {13'd0, busy, rand_en, valid, hand()}, 32'h6_0000);
      deal = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_in = 4'(i + 5);
         step();
      end
      chk("held_second_hand", {15'd0, valid, hand()}, 32'h1_5678);

      // MAX_VAL = 9 instance.
      deal9 = 1'b1;
      step();
      deal9 = 1'b0;
      chk("mv9_busy", {30'd0, busy9, rand_en9}, 32'd3);
      rand9 = 4'd10; step();
      rand9 = 4'd9;  step();
      rand9 = 4'd1;  step();
      rand9 = 4'd12; step();
      rand9 = 4'd4;  step();
      chk("mv9_not_early", {31'd0, valid9}, 32'd0);
      rand9 = 4'd6;  step();
      chk("mv9_hand", {15'd0, valid9, c90, c91, c92, c93}, 32'h1_9146);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
